// File: rtl/fetch_unit.sv
// Program counter and IF/ID pipeline register in front of a combinational
// instruction memory. Presents fetched instructions to decode with a
// valid/ready handshake and handles stall, branch redirect and halting at
// the end of the loaded program.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] MEM_LIMIT = 16'h0032,
    parameter logic [15:0] PC_STEP   = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc_out,
    input  logic [15:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] pc_r;
    logic [15:0] pc_s;
    logic        valid_r;
    logic        valid_s;
    logic [15:0] instr_r;
    logic [15:0] instr_s;
    logic [15:0] ipc_r;
    logic [15:0] ipc_s;
    logic [15:0] count_r;
    logic [15:0] count_s;

    logic        can_load_s;
    logic        drain_s;
    logic        at_limit_s;

    // The slot may be refilled when empty or when decode takes it this cycle;
    // an occupied slot accepted without refill is drained.
    assign can_load_s = !valid_r || id_ready;
    assign drain_s    = valid_r && id_ready;
    assign at_limit_s = (pc_r >= MEM_LIMIT);

    // Next-state and next-register values; redirect beats stall beats normal fetch.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        valid_s = valid_r;
        instr_s = instr_r;
        ipc_s   = ipc_r;
        count_s = count_r;
        if (branch_taken) begin
            pc_s    = branch_target & 16'hFFFE;
            valid_s = 1'b0;
            instr_s = 16'h0000;
            state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (stall) begin
                        if (drain_s) begin
                            valid_s = 1'b0;
                            instr_s = 16'h0000;
                        end else begin
                            valid_s = valid_r;
                        end
                    end else if (at_limit_s) begin
                        // End of program reached: stop fetching, let decode empty the slot.
                        state_s = ST_HALT;
                        if (drain_s) begin
                            valid_s = 1'b0;
                            instr_s = 16'h0000;
                        end else begin
                            valid_s = valid_r;
                        end
                    end else if (can_load_s) begin
                        instr_s = instr_in;
                        ipc_s   = pc_r;
                        valid_s = 1'b1;
                        pc_s    = pc_r + PC_STEP;
                        count_s = count_r + 16'h0001;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                ST_HALT: begin
                    if (drain_s) begin
                        valid_s = 1'b0;
                        instr_s = 16'h0000;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                default: begin
                    state_s = ST_RUN;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            valid_r <= 1'b0;
            instr_r <= 16'h0000;
            ipc_r   <= 16'h0000;
            count_r <= 16'h0000;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            valid_r <= valid_s;
            instr_r <= instr_s;
            ipc_r   <= ipc_s;
            count_r <= count_s;
        end
    end

    assign pc_out      = pc_r;
    assign if_id_valid = valid_r;
    assign if_id_instr = instr_r;
    assign if_id_pc    = ipc_r;
    assign halted      = (state_r == ST_HALT);
    assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.
module tb_fetch_unit;

    localparam logic [15:0] LIMIT = 16'h0032;

    logic        clk;
    logic        rst;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        id_ready;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0]  rom [0:255];

    int          n_checks;
    int          n_errors;

    // model state
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic        m_halted;
    logic [15:0] m_count;

    logic [15:0] saved_count;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_out       (pc_out),
        .instr_in     (instr_in),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .id_ready     (id_ready),
        .if_id_valid  (if_id_valid),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Little-endian combinational instruction memory.
    assign instr_in = {rom[pc_out[7:0] + 8'd1], rom[pc_out[7:0]]};

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {rom[lo + 8'd1], rom[lo]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model advanced once per rising edge using the pre-edge inputs.
    task automatic model_edge();
        if (rst) begin
            m_pc = 16'h0000; m_valid = 1'b0; m_instr = 16'h0000;
            m_ipc = 16'h0000; m_halted = 1'b0; m_count = 16'h0000;
        end else if (branch_taken) begin
            m_pc = {branch_target[15:1], 1'b0};
            m_valid = 1'b0; m_instr = 16'h0000; m_halted = 1'b0;
        end else if (m_halted || stall || m_pc >= LIMIT) begin
            if (!m_halted && !stall) m_halted = 1'b1;
            if (m_valid && id_ready) begin
                m_valid = 1'b0; m_instr = 16'h0000;
            end
        end else if (!m_valid || id_ready) begin
            m_instr = rom_word(m_pc);
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd2;
            m_count = m_count + 16'd1;
        end
    endtask

    task automatic compare_model();
        check("pc_out", pc_out, m_pc);
        check("valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        check("instr", if_id_instr, m_instr);
        check("if_id_pc", if_id_pc, m_ipc);
        check("halted", {15'd0, halted}, {15'd0, m_halted});
        check("count", fetch_count, m_count);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic set_in(input logic r, input logic s, input logic b,
                          input logic [15:0] t, input logic rd);
        rst = r; stall = s; branch_taken = b; branch_target = t; id_ready = rd;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pc = 16'h0000; m_valid = 1'b0; m_instr = 16'h0000;
        m_ipc = 16'h0000; m_halted = 1'b0; m_count = 16'h0000;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h34; rom[1] = 8'h12; rom[2] = 8'h78; rom[3] = 8'h56;

        // T1: reset held two cycles with a branch request present
        set_in(1'b1, 1'b0, 1'b1, 16'h0020, 1'b1);
        step();
        step();
        check("t1_pc", pc_out, 16'h0000);
        check("t1_valid", {15'd0, if_id_valid}, 16'h0000);
        check("t1_halted", {15'd0, halted}, 16'h0000);
        check("t1_count", fetch_count, 16'h0000);

        // T2: streaming fetch
        set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step();
        check("t2_instr0", if_id_instr, 16'h1234);
        check("t2_pc0", if_id_pc, 16'h0000);
        step();
        check("t2_instr1", if_id_instr, 16'h5678);
        check("t2_pc1", if_id_pc, 16'h0002);
        check("t2_pcout", pc_out, 16'h0004);
        check("t2_count", fetch_count, 16'h0002);

        // T3: backpressure
        set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step();
        rst = 1'b0;
        step();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_instr", if_id_instr, 16'h1234);
            check("t3_hold_pc", pc_out, 16'h0002);
        end
        id_ready = 1'b1;
        step();
        check("t3_resume", if_id_instr, 16'h5678);

        // T4: stall and branch in the same cycle
        saved_count = fetch_count;
        set_in(1'b0, 1'b1, 1'b1, 16'h0007, 1'b1);
        step();
        check("t4_pc", pc_out, 16'h0006);
        check("t4_valid", {15'd0, if_id_valid}, 16'h0000);
        check("t4_count", fetch_count, saved_count);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step();
        check("t4_ipc", if_id_pc, 16'h0006);
        check("t4_instr", if_id_instr, {rom[7], rom[6]});

        // T5: free run to the end of the program, then redirect
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 26; i++) step();
        check("t5_halted", {15'd0, halted}, 16'h0001);
        check("t5_pc", pc_out, 16'h0032);
        check("t5_count", fetch_count, 16'd25);
        check("t5_last_pc", if_id_pc, 16'h0030);
        step();
        check("t5_hold_pc", pc_out, 16'h0032);
        set_in(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1);
        step();
        check("t5_unhalt", {15'd0, halted}, 16'h0000);
        check("t5_redir", pc_out, 16'h0010);
        branch_taken = 1'b0;
        step();
        check("t5_resume", if_id_pc, 16'h0010);

        // T6: reset mid-run
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t6_pc", pc_out, 16'h000A);
        check("t6_valid", {15'd0, if_id_valid}, 16'h0001);
        rst = 1'b1;
        step();
        check("t6_rpc", pc_out, 16'h0000);
        check("t6_rvalid", {15'd0, if_id_valid}, 16'h0000);
        check("t6_rinstr", if_id_instr, 16'h0000);
        check("t6_ripc", if_id_pc, 16'h0000);
        check("t6_rcount", fetch_count, 16'h0000);
        rst = 1'b0;

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(63) == 0);
            branch_taken  = ($urandom_range(7) == 0);
            branch_target = 16'($urandom_range(16'h003F));
            stall         = ($urandom_range(3) == 0);
            id_ready      = ($urandom_range(1) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
